// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame sequencer.
package uart_tx_pkg;

  // Data bits per frame; bounded by the 3-bit serializer bit index.
  localparam int UART_DATA_WIDTH     = 8;
  localparam int UART_PRESCALE_WIDTH = 6;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // TX line mux select codes.
  localparam logic [1:0] MUX_START = 2'd0;
  localparam logic [1:0] MUX_STOP  = 2'd1;
  localparam logic [1:0] MUX_DATA  = 2'd2;
  localparam logic [1:0] MUX_PAR   = 2'd3;

  // Moore decode of the line select; unknown states park the line idle-high.
  function automatic logic [1:0] mux_for_state(state_t s);
    logic [1:0] sel;
    case (s)
      ST_IDLE:   sel = MUX_STOP;
      ST_START:  sel = MUX_START;
      ST_DATA:   sel = MUX_DATA;
      ST_PARITY: sel = MUX_PAR;
      ST_STOP:   sel = MUX_STOP;
      default:   sel = MUX_STOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts 0..period-1 and flags the last clock of each bit.
// Cleared whenever the sequencer changes state so every bit starts at 0.
module uart_tx_bit_timer
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = UART_PRESCALE_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_period,
  output logic             o_last
);

  logic [WIDTH-1:0] r_count;

  // Period counter: wraps on its last clock, reloads 0 on clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= {WIDTH{1'b0}};
    end else if (i_clear || o_last) begin
      r_count <= {WIDTH{1'b0}};
    end else begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  // Period is never 0 here: the controller captures a minimum of 1.
  assign o_last = (r_count == (i_period - WIDTH'(1)));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, 8 data bits LSB first, optional
// parity, stop. Each bit is held for the prescale value captured at accept.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int PRESCALE_WIDTH = UART_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Data_Valid,
  input  logic                      Par_En,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      Ser_Load,
  output logic                      Ser_En,
  output logic [2:0]                Counter,
  output logic [1:0]                Mux_Sel,
  output logic                      Busy,
  output logic                      Tx_Done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

  state_t                    r_state;
  state_t                    w_state_next;
  logic [2:0]                r_counter;
  logic [2:0]                w_counter_next;
  logic                      r_par_en;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [PRESCALE_WIDTH-1:0] w_prescale_eff;
  logic                      w_capture;
  logic                      w_ser_load;
  logic                      w_ser_en;
  logic                      w_tx_done;
  logic                      w_last;
  logic                      w_timer_clear;

  // Prescale values 0 and 1 both mean one clock per bit.
  assign w_prescale_eff = (Prescale == {PRESCALE_WIDTH{1'b0}}) ?
                          PRESCALE_WIDTH'(1) : Prescale;

  // Timer restarts on every state change and is held at 0 while idle.
  assign w_timer_clear = (w_state_next != r_state) || (r_state == ST_IDLE);

  uart_tx_bit_timer #(
    .WIDTH (PRESCALE_WIDTH)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_timer_clear),
    .i_period (r_prescale),
    .o_last   (w_last)
  );

  // State, bit index and captured frame configuration.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_counter  <= 3'd0;
      r_par_en   <= 1'b0;
      r_prescale <= PRESCALE_WIDTH'(1);
    end else begin
      r_state   <= w_state_next;
      r_counter <= w_counter_next;
      if (w_capture) begin
        r_par_en   <= Par_En;
        r_prescale <= w_prescale_eff;
      end else begin
        r_par_en   <= r_par_en;
        r_prescale <= r_prescale;
      end
    end
  end

  // Next-state and strobe decode; strobes are combinational in their cycle.
  always_comb begin
    w_state_next   = r_state;
    w_counter_next = r_counter;
    w_capture      = 1'b0;
    w_ser_load     = 1'b0;
    w_ser_en       = 1'b0;
    w_tx_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Data_Valid) begin
          w_ser_load   = 1'b1;
          w_capture    = 1'b1;
          w_state_next = ST_START;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_last) begin
          w_state_next = ST_DATA;
        end else begin
          w_state_next = ST_START;
        end
      end
      ST_DATA: begin
        if (w_last) begin
          w_ser_en = 1'b1;
          if (r_counter == LAST_BIT) begin
            w_counter_next = 3'd0;
            w_state_next   = r_par_en ? ST_PARITY : ST_STOP;
          end else begin
            w_counter_next = r_counter + 3'd1;
            w_state_next   = ST_DATA;
          end
        end else begin
          w_state_next = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (w_last) begin
          w_state_next = ST_STOP;
        end else begin
          w_state_next = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (w_last) begin
          w_tx_done    = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_STOP;
        end
      end
      default: begin
        w_state_next   = ST_IDLE;
        w_counter_next = 3'd0;
      end
    endcase
  end

  assign Ser_Load = w_ser_load;
  assign Ser_En   = w_ser_en;
  assign Tx_Done  = w_tx_done;
  assign Counter  = r_counter;
  assign Mux_Sel  = mux_for_state(r_state);
  assign Busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus pushes per-cycle expected
// outputs; a negedge monitor pops and compares, and checks idle otherwise.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dv;
  logic       par_en;
  logic [5:0] prescale;
  logic       ser_load;
  logic       ser_en;
  logic [2:0] counter;
  logic [1:0] mux_sel;
  logic       busy;
  logic       tx_done;

  uart_tx_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .Data_Valid (dv),
    .Par_En     (par_en),
    .Prescale   (prescale),
    .Ser_Load   (ser_load),
    .Ser_En     (ser_en),
    .Counter    (counter),
    .Mux_Sel    (mux_sel),
    .Busy       (busy),
    .Tx_Done    (tx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       load;
    logic       en;
    logic [2:0] cnt;
    logic [1:0] mux;
    logic       busy;
    logic       done;
    logic       line;
  } rec_t;

  rec_t q[$];
  rec_t r;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   push_limit = 32'h7fffffff;
  bit   mon_en = 1'b0;

  // Environment: serializer, parity and TX line mux around the sequencer.
  logic [7:0] p_data;
  logic [7:0] sr;
  logic       sr_par;
  logic       tx_line;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ser_load) begin
      sr     <= p_data;
      sr_par <= ^p_data;
    end else if (ser_en) begin
      sr <= sr >> 1;
    end
  end

  always_comb begin
    tx_line = 1'b1;
    case (mux_sel)
      2'd0:    tx_line = 1'b0;
      2'd1:    tx_line = 1'b1;
      2'd2:    tx_line = sr[0];
      2'd3:    tx_line = sr_par;
      default: tx_line = 1'b1;
    endcase
  end

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic void add(int c, logic load, logic en, logic [2:0] cnt,
                              logic [1:0] mux, logic bsy, logic done, logic line);
    rec_t e;
    e.cyc = c; e.load = load; e.en = en; e.cnt = cnt;
    e.mux = mux; e.busy = bsy; e.done = done; e.line = line;
    if (c <= push_limit) q.push_back(e);
  endfunction

  // Expected per-cycle outputs of one frame accepted in cycle k, p clocks/bit.
  function automatic void push_frame(int k, logic [7:0] d, logic par, int p);
    int c;
    c = k;
    add(c, 1'b1, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0, 1'b1); c++;
    for (int j = 0; j < p; j++) begin
      add(c, 1'b0, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0); c++;
    end
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < p; j++) begin
        add(c, 1'b0, (j == p - 1), 3'(b), 2'd2, 1'b1, 1'b0, d[b]); c++;
      end
    end
    if (par) begin
      for (int j = 0; j < p; j++) begin
        add(c, 1'b0, 1'b0, 3'd0, 2'd3, 1'b1, 1'b0, ^d); c++;
      end
    end
    for (int j = 0; j < p; j++) begin
      add(c, 1'b0, 1'b0, 3'd0, 2'd1, 1'b1, (j == p - 1), 1'b1); c++;
    end
  endfunction

  // Monitor: compare a scheduled record, otherwise require idle outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_record_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        r = q.pop_front();
        chk("ser_load", int'(ser_load), int'(r.load));
        chk("ser_en",   int'(ser_en),   int'(r.en));
        chk("counter",  int'(counter),  int'(r.cnt));
        chk("mux_sel",  int'(mux_sel),  int'(r.mux));
        chk("busy",     int'(busy),     int'(r.busy));
        chk("tx_done",  int'(tx_done),  int'(r.done));
        chk("tx_line",  int'(tx_line),  int'(r.line));
      end else begin
        chk("idle_outputs",
            int'({ser_load, ser_en, busy, tx_done, mux_sel, counter}),
            int'(9'b0_0_0_0_01_000));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request; expectation uses the effective (min 1) prescale.
  task automatic send(input logic [7:0] d, input logic par, input logic [5:0] pre);
    int p;
    p = (pre == 6'd0) ? 1 : int'(pre);
    p_data   = d;
    par_en   = par;
    prescale = pre;
    dv       = 1'b1;
    push_frame(cyc, d, par, p);
    tick();
    dv = 1'b0;
  endtask

  logic [7:0] vals [3];
  int         c_rst;

  initial begin
    rst = 1'b0; dv = 1'b0; par_en = 1'b0; prescale = 6'd0; p_data = 8'h00;
    vals[0] = 8'h5A; vals[1] = 8'hF0; vals[2] = 8'h01;
    repeat (3) tick();
    rst = 1'b1;
    mon_en = 1'b1;
    add(cyc, 1'b0, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0, 1'b1);
    tick();

    // Prescale 1, no parity: 10-cycle frame.
    send(8'h53, 1'b0, 6'd1);
    repeat (10) tick();

    // Prescale 4, even parity, 0xA5: 44-cycle frame.
    send(8'hA5, 1'b1, 6'd4);
    repeat (44) tick();

    // Data_Valid held high: back-to-back frames with one idle cycle.
    prescale = 6'd2;
    par_en   = 1'b0;
    dv       = 1'b1;
    for (int f = 0; f < 3; f++) begin
      p_data = vals[f];
      push_frame(cyc, vals[f], 1'b0, 2);
      if (f < 2) begin
        repeat (21) tick();
      end else begin
        tick();
        dv = 1'b0;
        repeat (20) tick();
      end
    end

    // Prescale 0 behaves as 1; mid-frame changes are ignored.
    send(8'h0F, 1'b0, 6'd0);
    prescale = 6'd8;
    par_en   = 1'b1;
    repeat (10) tick();
    send(8'h81, 1'b1, 6'd8);
    repeat (88) tick();

    // Reset during data bit 3 (Prescale 4), then a clean frame.
    c_rst = cyc + 1 + 4 + 3 * 4 + 1;
    push_limit = c_rst;
    send(8'h6E, 1'b0, 6'd4);
    push_limit = 32'h7fffffff;
    add(c_rst + 1, 1'b0, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0, 1'b1);
    add(c_rst + 2, 1'b0, 1'b0, 3'd0, 2'd1, 1'b0, 1'b0, 1'b1);
    while (cyc < c_rst) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    send(8'hC3, 1'b1, 6'd2);
    repeat (22) tick();

    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
